// File: rtl/legv8_insn_encoder_pkg.sv
// Shared LEGv8 encoder definitions: op enumeration, opcode fields, immediate limits.
// The op numbering and field constants here are intended to match the control decoder.
package legv8_insn_encoder_pkg;

    typedef enum logic [3:0] {
        OpAnd  = 4'd0,
        OpOrr  = 4'd1,
        OpAdd  = 4'd2,
        OpSub  = 4'd3,
        OpAddi = 4'd4,
        OpSubi = 4'd5,
        OpMovz = 4'd6,
        OpB    = 4'd7,
        OpCbz  = 4'd8,
        OpLdur = 4'd9,
        OpStur = 4'd10
    } op_e;

    typedef enum logic {StIdle, StWrite} state_e;

    localparam logic [1:0] ErrNone = 2'd0;
    localparam logic [1:0] ErrOp   = 2'd1;
    localparam logic [1:0] ErrImm  = 2'd2;

    localparam logic [10:0] OpcAnd  = 11'b10001010000;
    localparam logic [10:0] OpcOrr  = 11'b10101010000;
    localparam logic [10:0] OpcAdd  = 11'b10001011000;
    localparam logic [10:0] OpcSub  = 11'b11001011000;
    localparam logic [10:0] OpcLdur = 11'b11111000010;
    localparam logic [10:0] OpcStur = 11'b11111000000;
    localparam logic [9:0]  OpcAddi = 10'b1001000100;
    localparam logic [9:0]  OpcSubi = 10'b1101000100;
    localparam logic [8:0]  OpcMovz = 9'b110100101;
    localparam logic [5:0]  OpcB    = 6'b000101;
    localparam logic [7:0]  OpcCbz  = 8'b10110100;

    localparam int ImmU12Max = 4095;
    localparam int ImmU16Max = 65535;
    localparam int BImmMin   = -(2 ** 25);
    localparam int BImmMax   = (2 ** 25) - 1;
    localparam int CbzImmMin = -(2 ** 18);
    localparam int CbzImmMax = (2 ** 18) - 1;
    localparam int DImmMin   = -256;
    localparam int DImmMax   = 255;

endpackage

// File: rtl/legv8_insn_encoder_field_pack.sv
// Combinational instruction packer: builds the 32-bit word and range-checks the immediate.
module legv8_insn_encoder_field_pack
    import legv8_insn_encoder_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rn_i,
    input  logic [4:0]  rm_i,
    input  logic [31:0] imm_i,
    input  logic [1:0]  hw_i,
    output logic [31:0] word_o,
    output logic        ok_o,
    output logic [1:0]  err_code_o
);

    logic signed [31:0] simm;
    logic               op_ok;
    logic               imm_ok;
    logic [31:0]        raw;

    assign simm = imm_i;

    always_comb begin
        raw    = '0;
        op_ok  = 1'b1;
        imm_ok = 1'b1;
        case (op_e'(op_i))
            OpAnd:  raw = {OpcAnd, rm_i, 6'd0, rn_i, rd_i};
            OpOrr:  raw = {OpcOrr, rm_i, 6'd0, rn_i, rd_i};
            OpAdd:  raw = {OpcAdd, rm_i, 6'd0, rn_i, rd_i};
            OpSub:  raw = {OpcSub, rm_i, 6'd0, rn_i, rd_i};
            OpAddi: begin
                imm_ok = (simm >= 0) && (simm <= ImmU12Max);
                raw    = {OpcAddi, imm_i[11:0], rn_i, rd_i};
            end
            OpSubi: begin
                imm_ok = (simm >= 0) && (simm <= ImmU12Max);
                raw    = {OpcSubi, imm_i[11:0], rn_i, rd_i};
            end
            OpMovz: begin
                imm_ok = (simm >= 0) && (simm <= ImmU16Max);
                raw    = {OpcMovz, hw_i, imm_i[15:0], rd_i};
            end
            OpB: begin
                imm_ok = (simm >= BImmMin) && (simm <= BImmMax);
                raw    = {OpcB, imm_i[25:0]};
            end
            OpCbz: begin
                imm_ok = (simm >= CbzImmMin) && (simm <= CbzImmMax);
                raw    = {OpcCbz, imm_i[18:0], rd_i};
            end
            OpLdur: begin
                imm_ok = (simm >= DImmMin) && (simm <= DImmMax);
                raw    = {OpcLdur, imm_i[8:0], 2'b00, rn_i, rd_i};
            end
            OpStur: begin
                imm_ok = (simm >= DImmMin) && (simm <= DImmMax);
                raw    = {OpcStur, imm_i[8:0], 2'b00, rn_i, rd_i};
            end
            default: op_ok = 1'b0;
        endcase
    end

    // An unknown op reports ErrOp even though imm_ok may still be set.
    always_comb begin
        ok_o       = op_ok && imm_ok;
        word_o     = ok_o ? raw : '0;
        err_code_o = !op_ok ? ErrOp : (!imm_ok ? ErrImm : ErrNone);
    end

endmodule

// File: rtl/legv8_insn_encoder.sv
// Encodes LEGv8 instruction requests and writes them sequentially into instruction memory.
module legv8_insn_encoder
    import legv8_insn_encoder_pkg::*;
#(
    parameter int unsigned ADDR_W    = 6,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              CLK,
    input  logic              resetl,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rn,
    input  logic [4:0]        in_rm,
    input  logic [31:0]       in_imm,
    input  logic [1:0]        in_hw,
    output logic              imem_req,
    input  logic              imem_gnt,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              err,
    output logic [1:0]        err_code,
    output logic              full,
    output logic [ADDR_W:0]   count
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              full_q, full_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              err_q, err_d;
    logic [1:0]        err_code_q, err_code_d;
    logic              live_q;

    logic [31:0] pack_word;
    logic        pack_ok;
    logic [1:0]  pack_code;

    legv8_insn_encoder_field_pack u_pack (
        .op_i      (in_op),
        .rd_i      (in_rd),
        .rn_i      (in_rn),
        .rm_i      (in_rm),
        .imm_i     (in_imm),
        .hw_i      (in_hw),
        .word_o    (pack_word),
        .ok_o      (pack_ok),
        .err_code_o(pack_code)
    );

    // live_q keeps in_ready low until the first edge after reset release.
    assign in_ready   = live_q && (state_q == StIdle) && !full_q && !start;
    assign imem_req   = (state_q == StWrite);
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign err        = err_q;
    assign err_code   = err_code_q;
    assign full       = full_q;
    assign count      = count_q;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        count_d    = count_q;
        full_d     = full_q;
        wdata_d    = wdata_q;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        if (start) begin
            state_d = StIdle;
            addr_d  = ADDR_W'(BASE_ADDR);
            count_d = '0;
            full_d  = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid && in_ready) begin
                        if (pack_ok) begin
                            wdata_d = pack_word;
                            state_d = StWrite;
                        end else begin
                            err_d      = 1'b1;
                            err_code_d = pack_code;
                        end
                    end
                end
                StWrite: begin
                    if (imem_gnt) begin
                        state_d = StIdle;
                        count_d = count_q + (ADDR_W + 1)'(1);
                        if (&addr_q) begin
                            full_d = 1'b1;
                        end else begin
                            addr_d = addr_q + ADDR_W'(1);
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            state_q    <= StIdle;
            addr_q     <= ADDR_W'(BASE_ADDR);
            count_q    <= '0;
            full_q     <= 1'b0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
            err_code_q <= ErrNone;
            live_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            live_q     <= 1'b1;
        end
    end

endmodule
